// File: rtl/jpeg_udp_packer.sv
// Buffers the encoder's JPEG byte stream in a byte FIFO and emits it as UDP payloads,
// each a 4-byte frame/packet header followed by up to PAYLOAD_MAX JPEG bytes.
module jpeg_udp_packer #(
    parameter int FIFO_AW     = 12,
    parameter int PAYLOAD_MAX = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  img_data,
    input  logic        img_valid,
    input  logic        img_done,
    input  logic        I_mac_init_ready,
    input  logic        I_udp_busy,
    input  logic        I_udp_isLoadData,
    output logic        O_udp_tx_en,
    output logic [7:0]  O_udp_data,
    output logic [15:0] O_udp_data_len,
    output logic [15:0] O_ipv4_sign,
    output logic        O_overflow,
    output logic        O_frame_err
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
    localparam logic [CW-1:0]      PMAX     = CW'(PAYLOAD_MAX);
    localparam logic [CW-1:0]      FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]      CNT_ONE  = 1;
    localparam logic [FIFO_AW-1:0] PTR_ONE  = 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_HDR, S_DATA, S_FIN} state_t;
    state_t state_reg, state_next;

    logic [7:0]         mem [DEPTH];
    logic [7:0]         rd_data_reg;
    logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_addr;
    logic [CW-1:0]      fifo_count_reg, fifo_count_next;
    logic [CW-1:0]      tail_cnt_reg, data_left_reg, launch_n;
    logic               eof_seen_reg, last_reg, launch_last;
    logic [15:0]        frame_id_reg, sign_reg, len_reg;
    logic [14:0]        pkt_idx_reg;
    logic [1:0]         hdr_idx_reg;
    logic               overflow_reg, frame_err_reg;
    logic               full, push, pop, launch, skip_empty, pkt_end;
    logic [31:0]        hdr_word;
    logic [7:0]         hdr_byte [4];

    assign full    = (fifo_count_reg == FULL_CNT);
    assign push    = img_valid && !full;
    assign pop     = (state_reg == S_DATA) && I_udp_isLoadData;
    // Read one address ahead on a pop so the next byte is already registered.
    assign rd_addr = pop ? rd_ptr_reg + PTR_ONE : rd_ptr_reg;

    assign hdr_word = {frame_id_reg, last_reg, pkt_idx_reg};
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_hdr
            assign hdr_byte[gi] = hdr_word[31-8*gi -: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= img_data;
        rd_data_reg <= mem[rd_addr];
    end

    always_comb begin
        fifo_count_next = fifo_count_reg;
        if (push && !pop)
            fifo_count_next = fifo_count_reg + CNT_ONE;
        else if (pop && !push)
            fifo_count_next = fifo_count_reg - CNT_ONE;
    end

    always_comb begin
        state_next  = state_reg;
        launch      = 1'b0;
        launch_n    = PMAX;
        launch_last = 1'b0;
        skip_empty  = 1'b0;
        pkt_end     = 1'b0;
        O_udp_tx_en = 1'b0;
        O_udp_data  = 8'h00;
        case (state_reg)
            S_IDLE: begin
                if (I_mac_init_ready && !I_udp_busy) begin
                    if (eof_seen_reg && tail_cnt_reg != '0) begin
                        launch      = 1'b1;
                        launch_last = (tail_cnt_reg <= PMAX);
                        launch_n    = launch_last ? tail_cnt_reg : PMAX;
                        state_next  = S_START;
                    end else if (eof_seen_reg) begin
                        skip_empty = 1'b1;
                    end else if (fifo_count_reg >= PMAX) begin
                        launch     = 1'b1;
                        state_next = S_START;
                    end
                end
            end
            S_START: begin
                O_udp_tx_en = 1'b1;
                state_next  = S_WAIT;
            end
            S_WAIT: begin
                // Header byte 0 is presented while waiting; the first load consumes it.
                O_udp_data = hdr_byte[0];
                if (I_udp_isLoadData) state_next = S_HDR;
            end
            S_HDR: begin
                O_udp_data = hdr_byte[hdr_idx_reg];
                if (I_udp_isLoadData && hdr_idx_reg == 2'd3) state_next = S_DATA;
            end
            S_DATA: begin
                O_udp_data = rd_data_reg;
                if (I_udp_isLoadData && data_left_reg == CNT_ONE) state_next = S_FIN;
            end
            S_FIN: begin
                if (!I_udp_busy) begin
                    pkt_end    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
            tail_cnt_reg   <= '0;
            data_left_reg  <= '0;
            eof_seen_reg   <= 1'b0;
            last_reg       <= 1'b0;
            frame_id_reg   <= '0;
            sign_reg       <= '0;
            len_reg        <= '0;
            pkt_idx_reg    <= '0;
            hdr_idx_reg    <= '0;
            overflow_reg   <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            fifo_count_reg <= fifo_count_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            if (img_valid && full) overflow_reg <= 1'b1;
            if (img_done && eof_seen_reg) frame_err_reg <= 1'b1;

            // The open byte count includes any byte written in the same cycle as img_done.
            if (img_done && !eof_seen_reg) begin
                eof_seen_reg <= 1'b1;
                tail_cnt_reg <= fifo_count_next;
            end else if (pop && eof_seen_reg) begin
                tail_cnt_reg <= tail_cnt_reg - CNT_ONE;
            end

            if (launch) begin
                len_reg       <= 16'd4 + 16'(launch_n);
                data_left_reg <= launch_n;
                last_reg      <= launch_last;
                hdr_idx_reg   <= 2'd0;
            end
            if (state_reg == S_WAIT && I_udp_isLoadData) hdr_idx_reg <= 2'd1;
            if (state_reg == S_HDR && I_udp_isLoadData)  hdr_idx_reg <= hdr_idx_reg + 2'd1;
            if (pop) data_left_reg <= data_left_reg - CNT_ONE;

            if (skip_empty) begin
                frame_id_reg <= frame_id_reg + 16'd1;
                eof_seen_reg <= 1'b0;
            end
            if (pkt_end) begin
                sign_reg <= sign_reg + 16'd1;
                if (last_reg) begin
                    frame_id_reg <= frame_id_reg + 16'd1;
                    pkt_idx_reg  <= '0;
                    eof_seen_reg <= 1'b0;
                end else begin
                    pkt_idx_reg <= pkt_idx_reg + 15'd1;
                end
            end
        end
    end

    assign O_udp_data_len = len_reg;
    assign O_ipv4_sign    = sign_reg;
    assign O_overflow     = overflow_reg;
    assign O_frame_err    = frame_err_reg;
endmodule
